// File: rtl/divider_sequencer.sv
// Iterative RV32M divide unit: restoring shift-subtract over WIDTH cycles, with
// fast paths for divide-by-zero and signed overflow, and a stall handshake to the hazard unit.
module divider_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             StartE,
    input  logic [1:0]       DivOpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             FlushE,
    input  logic             Stall,
    output logic             DivBusyE,
    output logic             DivValidE,
    output logic [WIDTH-1:0] DivResultE
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic logic [WIDTH-1:0] neg2(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic             neg_q;
    logic             neg_r;
    logic             op_rem;

    logic             signed_op;
    logic             is_rem;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             div_zero;
    logic             ovf;
    logic [WIDTH-1:0] special_res;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] final_res;

    // Operand decode for the acceptance cycle in IDLE
    always_comb begin
        signed_op   = ~DivOpE[0];
        is_rem      = DivOpE[1];
        a_neg       = signed_op & SrcAE[WIDTH-1];
        b_neg       = signed_op & SrcBE[WIDTH-1];
        a_abs       = a_neg ? neg2(SrcAE) : SrcAE;
        b_abs       = b_neg ? neg2(SrcBE) : SrcBE;
        div_zero    = (SrcBE == '0);
        ovf         = signed_op & (SrcAE == {1'b1, {(WIDTH-1){1'b0}}}) & (SrcBE == '1);
        special_res = '0;
        if (div_zero)
            special_res = is_rem ? SrcAE : '1;
        else
            special_res = is_rem ? '0 : SrcAE;
    end

    // One restoring step; the extra remainder bit makes trial[WIDTH] the borrow
    always_comb begin
        shifted   = {rem[WIDTH-1:0], quo[WIDTH-1]};
        trial     = shifted - {1'b0, dvsr};
        rem_nxt   = trial[WIDTH] ? shifted : trial;
        quo_nxt   = {quo[WIDTH-2:0], ~trial[WIDTH]};
        final_res = op_rem ? (neg_r ? neg2(rem_nxt[WIDTH-1:0]) : rem_nxt[WIDTH-1:0])
                           : (neg_q ? neg2(quo_nxt) : quo_nxt);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            cnt        <= '0;
            rem        <= '0;
            quo        <= '0;
            dvsr       <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            op_rem     <= 1'b0;
            DivResultE <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (StartE && !FlushE) begin
                        if (div_zero || ovf) begin
                            DivResultE <= special_res;
                            state      <= DONE;
                        end else begin
                            dvsr   <= b_abs;
                            quo    <= a_abs;
                            rem    <= '0;
                            neg_q  <= signed_op & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
                            neg_r  <= a_neg;
                            op_rem <= is_rem;
                            cnt    <= CW'(WIDTH - 1);
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    // A dropped StartE here can only come from a flush; treat it as abort
                    if (FlushE || !StartE) begin
                        state <= IDLE;
                    end else begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        cnt <= cnt - CW'(1);
                        if (cnt == '0) begin
                            DivResultE <= final_res;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (FlushE || !Stall)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Busy is combinational so the acceptance cycle already stalls the pipeline
    assign DivBusyE  = resetn & StartE & ~FlushE & (state != DONE);
    assign DivValidE = (state == DONE);

endmodule

// File: tb/tb_divider_sequencer.sv
// Directed bench for divider_sequencer: signed/unsigned results, fast paths,
// busy latency, flush abort, DONE stall hold and asynchronous reset.
module tb_divider_sequencer;

    logic        clk;
    logic        resetn;
    logic        StartE;
    logic [1:0]  DivOpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        FlushE;
    logic        Stall;
    logic        DivBusyE;
    logic        DivValidE;
    logic [31:0] DivResultE;

    int pass_cnt = 0;
    int total    = 0;

    divider_sequencer #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .StartE     (StartE),
        .DivOpE     (DivOpE),
        .SrcAE      (SrcAE),
        .SrcBE      (SrcBE),
        .FlushE     (FlushE),
        .Stall      (Stall),
        .DivBusyE   (DivBusyE),
        .DivValidE  (DivValidE),
        .DivResultE (DivResultE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Entered and left at posedge+1 with the unit in IDLE
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_busy, input int stall_cycles,
                         input string tag);
        int   busy;
        logic got;
        busy   = 0;
        got    = 1'b0;
        DivOpE = op;
        SrcAE  = a;
        SrcBE  = b;
        StartE = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (DivValidE) begin
                got = 1'b1;
                break;
            end
            if (DivBusyE) busy++;
            @(posedge clk);
        end
        chk({tag, " valid"}, {31'd0, got}, 32'd1);
        chk({tag, " busy_cycles"}, 32'(busy), 32'(exp_busy));
        chk({tag, " result"}, DivResultE, exp_res);
        Stall = (stall_cycles > 0);
        for (int s = 0; s < stall_cycles; s++) begin
            @(posedge clk);
            #1;
            chk({tag, " stall_valid"}, {31'd0, DivValidE}, 32'd1);
            chk({tag, " stall_result"}, DivResultE, exp_res);
        end
        Stall = 1'b0;
        @(posedge clk);
        #1;
        StartE = 1'b0;
        chk({tag, " valid_drop"}, {31'd0, DivValidE}, 32'd0);
    endtask

    initial begin
        int seen;
        resetn = 1'b0;
        StartE = 1'b0;
        DivOpE = 2'b00;
        SrcAE  = '0;
        SrcBE  = '0;
        FlushE = 1'b0;
        Stall  = 1'b0;
        #12;
        chk("reset valid", {31'd0, DivValidE}, 32'd0);
        chk("reset busy", {31'd0, DivBusyE}, 32'd0);
        chk("reset result", DivResultE, 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        do_op(2'b01, 32'd100, 32'd7, 32'd14, 33, 0, "divu_100_7");
        do_op(2'b11, 32'd100, 32'd7, 32'd2, 33, 0, "remu_100_7");
        do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0, "div_m7_2");
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0, "rem_m7_2");
        do_op(2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0, "div_7_m2");
        do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 0, "rem_7_m2");
        do_op(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, "divu_5_0");
        do_op(2'b11, 32'd5, 32'd0, 32'd5, 1, 0, "remu_5_0");

        // Flush on the 10th CALC cycle of DIVU 1000/10
        DivOpE = 2'b01;
        SrcAE  = 32'd1000;
        SrcBE  = 32'd10;
        StartE = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1;
        FlushE = 1'b1;
        #1;
        chk("flush busy", {31'd0, DivBusyE}, 32'd0);
        @(posedge clk);
        #1;
        FlushE = 1'b0;
        StartE = 1'b0;
        chk("flush valid", {31'd0, DivValidE}, 32'd0);
        chk("flush result_kept", DivResultE, 32'd5);
        do_op(2'b01, 32'd9, 32'd3, 32'd3, 33, 0, "divu_9_3_after_flush");

        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "div_ovf");
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, "rem_ovf");
        do_op(2'b01, 32'd1000, 32'd10, 32'd100, 33, 3, "divu_stall3");

        // Asynchronous reset pulse in the middle of CALC
        DivOpE = 2'b01;
        SrcAE  = 32'd100;
        SrcBE  = 32'd7;
        StartE = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("areset result", DivResultE, 32'd0);
        chk("areset valid", {31'd0, DivValidE}, 32'd0);
        chk("areset busy", {31'd0, DivBusyE}, 32'd0);
        StartE = 1'b0;
        #3;
        resetn = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (DivValidE || DivBusyE) seen++;
        end
        chk("areset stays_idle", 32'(seen), 32'd0);
        chk("areset result_after", DivResultE, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/divider_sequencer.md
# divider_sequencer

Iterative RV32M divide unit and its sequencer, living beside the ALU in the execute stage. It accepts DIV/DIVU/REM/REMU operands after forwarding, runs a 32-iteration restoring shift-subtract loop, and short-circuits divide-by-zero and signed overflow. It raises a stall request to the hazard unit so the divide instruction holds in execute until the result is ready. It then presents a registered result that the execute-stage result mux steers into AluResultM.

## Interface
- WIDTH, 32: operand/result width; iteration count equals WIDTH.
- clk  in  1  pipeline clock.
- resetn  in  1  reset; one clock, reset is asynchronous and active-low.
- StartE  in  1  valid divide instruction currently in execute.
- DivOpE  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- SrcAE  in  WIDTH  dividend, already forwarded.
- SrcBE  in  WIDTH  divisor, already forwarded.
- FlushE  in  1  kill of the execute-stage instruction; aborts any operation.
- Stall  in  1  downstream pipeline stall; holds a finished result.
- DivBusyE  out  1  stall request to the hazard unit.
- DivValidE  out  1  DivResultE is valid for the instruction in execute.
- DivResultE  out  WIDTH  quotient or remainder, registered.

## Operation
- States: IDLE, CALC, DONE. Reset enters IDLE.
- IDLE, StartE=1, FlushE=0:
  - Divisor==0: result is all ones for DIV/DIVU and SrcAE for REM/REMU. Next state is DONE.
  - DIV/REM with SrcAE=0x80000000 and SrcBE=0xFFFFFFFF: result is 0x80000000 for DIV and 0 for REM. Next state is DONE.
  - Otherwise:
    - Latch |SrcAE| and |SrcBE|; absolute values apply only to signed ops.
    - Latch neg_q = signed op & sign(A)^sign(B), and neg_r = signed op & sign(A).
    - Latch op select; clear the partial remainder; load counter = WIDTH-1. Next state is CALC.
- CALC, each cycle:
  - {rem,quo} shift left by 1; trial = rem - divisor.
  - If the trial is non-negative: rem = trial and quo[0]=1.
  - Counter decrements. When counter==0, the step still executes and the sign-fixed result is written to DivResultE:
    - quotient negated if neg_q;
    - remainder negated if neg_r.
  - Next state is DONE.
- DONE: DivValidE=1. Stay while Stall=1. Go to IDLE when Stall=0, because the instruction leaves execute that edge.
- DivBusyE = StartE & ~FlushE & (state != DONE). It is combinational, so the acceptance cycle already stalls.
- FlushE=1 in any state forces IDLE next edge. DivValidE is not asserted, and DivResultE keeps its old value.
- StartE dropping in CALC (which only happens via flush) is treated as abort and returns to IDLE.
- DivResultE holds its last value in IDLE; it is never cleared except by reset.
- Arithmetic: the partial remainder is WIDTH+1 bits so the trial sign is the borrow. Negation is two's complement modulo 2^WIDTH.

## Timing
- Reset (async, immediate): state=IDLE, DivResultE=0, DivValidE=0, DivBusyE=0, counter=0, all latches 0.
- Normal op accepted at edge T (the IDLE cycle ends):
  - CALC occupies cycles T+1..T+WIDTH (32 cycles).
  - DONE is entered at T+WIDTH+1.
  - DivBusyE is high for WIDTH+1 = 33 cycles, then DivValidE is high.
- Special case (div-by-zero or overflow): DivBusyE is high for 1 cycle and DONE is the next cycle.
- DONE with Stall=1 for N cycles: DivValidE and DivResultE are stable for N+1 cycles.
- Back-to-back divides: the second instruction arrives in execute the cycle after DONE→IDLE. It is accepted in IDLE the same cycle; there are no bubbles beyond the IDLE acceptance cycle.
- FlushE and DONE in the same cycle: the flush wins, the next state is IDLE, and the result is discarded by the pipeline.
- Async reset mid-CALC: everything returns to IDLE at once. No valid appears after reset is released until a new StartE arrives.

## Test plan
- DIVU 100/7: DivBusyE high for exactly 33 cycles, then DivValidE=1 with DivResultE=14. REMU of the same operands gives 2.
- DIV -7/2 gives 0xFFFFFFFD (-3); REM -7/2 gives 0xFFFFFFFF (-1); DIV 7/-2 gives 0xFFFFFFFD; REM 7/-2 gives 1.
- DIVU 5/0 gives 0xFFFFFFFF and REMU 5/0 gives 5. In both, DivBusyE is high for 1 cycle and DivValidE follows on the next cycle.
- DIV 0x80000000/0xFFFFFFFF gives 0x80000000 and REM of the same operands gives 0. Both take 1 busy cycle.
- FlushE at cycle 10 of CALC: IDLE next cycle, DivValidE never asserts, and DivResultE is unchanged. An immediate new DIVU 9/3 returns 3 after 33 busy cycles.
- Stall=1 for 3 cycles in DONE: DivValidE is held for 4 cycles with a stable result.
- Async resetn pulse mid-CALC: outputs are 0 immediately and the unit stays IDLE afterwards.
